vc_input_demux: RTL and testbench
=================================

// Module: vc_input_demux
// PURPOSE
//  Receive-side counterpart of the switch-side VC plane multiplexer. Accepts one flit stream
//  from a link together with its VC tag. Steers each flit into one of VC per-VC FIFOs.
//  Presents every VC plane to the downstream VC mux / switch as a packed valid/ready bus.
//  One instance per router input port.
// PARAMETERS
//  VC           4   number of virtual channels (>=1)
//  DATA_WIDTH   32  flit width in bits
//  DEPTH        4   entries per VC FIFO; power of 2, >=2
//  VC_ID_WIDTH  2   width of the VC tag; 2**VC_ID_WIDTH >= VC
// PORTS
//  clk             in   1                 clock, all state on rising edge
//  rst             in   1                 asynchronous, active-high reset
//  data_in         in   DATA_WIDTH        flit from link
//  vc_in           in   VC_ID_WIDTH       VC tag of data_in
//  valid_in        in   1                 flit valid
//  ready_in        out  1                 flit accepted when valid_in & ready_in
//  data_out_portVC  out VC*DATA_WIDTH     head flit of VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//  valid_out_portVC out VC                bit i: FIFO i non-empty
//  ready_out_portVC in  VC                bit i: downstream pops VC i head this cycle
//  vc_full         out  VC                bit i: FIFO i holds DEPTH entries
//  vc_error        out  1                 sticky: flit with vc_in >= VC was seen
// BEHAVIOUR
//  Reset (async assert, sync use of deassert):
//   - All FIFO pointers and counts = 0.
//   - valid_out_portVC = 0, vc_full = 0, vc_error = 0.
//   - data_out_portVC = 0; FIFO storage need not be cleared, but data_out must read 0 while empty.
//  Write side:
//   - ready_in = ~vc_full[vc_in] when vc_in < VC.
//   - ready_in = 1 when vc_in >= VC. The flit is consumed, discarded and sets vc_error.
//   - ready_in is combinational on vc_in and FIFO state only; it never depends on valid_in.
//   - On valid_in & ready_in with a legal tag, data_in is written at the FIFO[vc_in] tail and the
//     write pointer advances mod DEPTH.
//  Read side (per VC, independent):
//   - valid_out_portVC[i] = count_i != 0.
//   - data_out_portVC slice i = FIFO[i] head.
//   - On valid_out_portVC[i] & ready_out_portVC[i], the read pointer advances mod DEPTH.
//   - ready_out_portVC[i] while empty is ignored; there is no underflow.
//  Latency:
//   - A flit written at edge N is visible at the output after edge N (1 cycle).
//   - There is no same-cycle bypass from data_in to data_out.
//  Simultaneous events:
//   - Push and pop on the same VC in one cycle: count unchanged, both pointers advance.
//   - Push on a full VC is impossible (ready_in=0). A pop that same cycle does NOT make the push
//     legal; the freed slot is usable next cycle.
//   - Pushes to VC a and pops from VC b≠a proceed independently.
//  Counts:
//   - count_i is $clog2(DEPTH)+1 bits, range 0..DEPTH.
//   - vc_full[i] = (count_i == DEPTH).
//   - Pointers are $clog2(DEPTH) bits and wrap naturally.
//  Ordering: FIFO order within a VC. Flits in different VCs carry no mutual ordering guarantee.
//  vc_error: cleared only by rst.
//  Reset mid-operation: all buffered flits are lost. Outputs return to reset values immediately
//   on rst assertion.
// TESTING
//  1. Reset, then push 0xA0 on VC2 -> next cycle valid_out_portVC=4'b0100, slice2=0xA0; pop -> 0.
//  2. Push 4 flits 0x1..0x4 on VC1, no pops -> vc_full=4'b0010, ready_in=0 for vc_in=1,
//     ready_in=1 for vc_in=0; then pops return 0x1,0x2,0x3,0x4 in order.
//  3. VC1 full; in one cycle push (vc_in=1) + pop VC1 -> push refused (ready_in=0), count=3;
//     next cycle push accepted, count=4.
//  4. VC0 holds 2 flits; push+pop VC0 every cycle for 20 cycles -> count stays 2, data in order
//     across pointer wrap.
//  5. With VC=3, push with vc_in=3 -> ready_in=1, no FIFO changes, vc_error=1 and stays 1 until rst.
//  6. Assert rst asynchronously mid-burst with all VCs non-empty -> valid_out_portVC=0, vc_full=0
//     immediately; first push after release lands at head.

Source files
------------

// File: rtl/vc_input_demux.sv
// vc_input_demux
// Receive-side VC demultiplexer for one router input port. A single link flit
// stream, tagged with its virtual channel, is steered into one of VC small
// FIFOs. Each FIFO head is presented downstream as an independent
// valid/ready plane on packed buses.
//
// Flow control towards the link is combinational on the VC tag and the FIFO
// occupancy only, so the upstream sender can evaluate credit before it
// commits a flit. Flits carrying an out-of-range tag are swallowed, never
// stall the link, and latch a sticky error flag that only reset clears.

module vc_input_demux #(
    parameter int VC          = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int VC_ID_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [VC_ID_WIDTH-1:0]   vc_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [VC*DATA_WIDTH-1:0] data_out_portVC,
    output logic [VC-1:0]            valid_out_portVC,
    input  logic [VC-1:0]            ready_out_portVC,
    output logic [VC-1:0]            vc_full,
    output logic                     vc_error
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    // A tag is legal when it names one of the instantiated VCs.
    function automatic logic tag_is_legal(input logic [VC_ID_WIDTH-1:0] tag);
        logic [31:0] tag_ext;
        tag_ext = 32'(tag);
        return (tag_ext < 32'(VC));
    endfunction

    logic            tag_legal_s;
    logic [VC-1:0]   sel_s;
    logic [VC-1:0]   full_s;
    logic [VC-1:0]   nonempty_s;
    logic [VC-1:0]   push_s;
    logic [VC-1:0]   pop_s;
    logic            ready_s;
    logic            error_set_s;
    logic            vc_error_q;
    logic            vc_error_d;

    // Decode the incoming tag and derive link-side flow control and the per-VC push strobes.
    always_comb begin
        sel_s       = '0;
        tag_legal_s = tag_is_legal(vc_in);
        for (int i = 0; i < VC; i++) begin
            sel_s[i] = (vc_in == VC_ID_WIDTH'(i));
        end
        if (tag_legal_s) begin
            // A pop on the selected VC this cycle does not free room for the push:
            // readiness is taken from the registered occupancy only.
            ready_s = ~|(sel_s & full_s);
        end else begin
            // Illegal tags are always accepted so a bad sender cannot wedge the link.
            ready_s = 1'b1;
        end
        push_s      = {VC{valid_in & tag_legal_s}} & sel_s & ~full_s;
        error_set_s = valid_in & ~tag_legal_s;
    end

    // Sticky error flag accumulates every illegal-tag flit until reset.
    always_comb begin
        vc_error_d = vc_error_q;
        if (error_set_s) begin
            vc_error_d = 1'b1;
        end else begin
            vc_error_d = vc_error_q;
        end
    end

    // Sticky error register; only the asynchronous reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc_error_q <= 1'b0;
        end else begin
            vc_error_q <= vc_error_d;
        end
    end

    for (genvar g = 0; g < VC; g++) begin : g_vc
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_d;
        logic [CNT_W-1:0]      count_q;
        logic [CNT_W-1:0]      count_d;
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] head_s;

        // Occupancy flags and the downstream pop strobe (pops while empty are ignored).
        always_comb begin
            nonempty_s[g] = (count_q != CNT_ZERO);
            full_s[g]     = (count_q == FULL_CNT);
            pop_s[g]      = nonempty_s[g] & ready_out_portVC[g];
        end

        // Pointer and occupancy next-state; simultaneous push and pop leaves the count unchanged.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push_s[g]) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s[g]) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s[g], pop_s[g]})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Pointer and occupancy registers; reset drops every buffered flit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Flit storage; contents are don't-care while the slot is not occupied, so no reset.
        always_ff @(posedge clk) begin
            if (push_s[g]) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end

        // Head flit is forced to zero while empty so stale storage never leaks downstream.
        always_comb begin
            if (nonempty_s[g]) begin
                head_s = mem_q[rd_ptr_q];
            end else begin
                head_s = '0;
            end
        end

        assign data_out_portVC[g*DATA_WIDTH +: DATA_WIDTH] = head_s;
    end

    assign ready_in         = ready_s;
    assign valid_out_portVC = nonempty_s;
    assign vc_full          = full_s;
    assign vc_error         = vc_error_q;

endmodule

// File: tb/tb_vc_input_demux.sv
// Testbench for vc_input_demux: table-driven vectors with constant expectations
// plus a per-VC reference queue that predicts every head flit.
module tb_vc_input_demux;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  data_in;
    logic [1:0]   vc_in;
    logic         valid_in;
    logic         ready_in;
    logic [127:0] data_out;
    logic [3:0]   valid_out;
    logic [3:0]   ready_out;
    logic [3:0]   vc_full;
    logic         vc_error;

    logic         rst3;
    logic [31:0]  data_in3;
    logic [1:0]   vc_in3;
    logic         valid_in3;
    logic         ready_in3;
    logic [95:0]  data_out3;
    logic [2:0]   valid_out3;
    logic [2:0]   ready_out3;
    logic [2:0]   vc_full3;
    logic         vc_error3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [4][$];

    typedef struct {
        logic        vld;
        logic [1:0]  vc;
        logic [31:0] data;
        logic [3:0]  pop;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_full;
    } vec_t;

    vec_t tbl [14];

    vc_input_demux #(.VC(4), .DATA_WIDTH(32), .DEPTH(4), .VC_ID_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .vc_in(vc_in), .valid_in(valid_in),
        .ready_in(ready_in), .data_out_portVC(data_out), .valid_out_portVC(valid_out),
        .ready_out_portVC(ready_out), .vc_full(vc_full), .vc_error(vc_error)
    );

    vc_input_demux #(.VC(3), .DATA_WIDTH(32), .DEPTH(4), .VC_ID_WIDTH(2)) u_dut3 (
        .clk(clk), .rst(rst3), .data_in(data_in3), .vc_in(vc_in3), .valid_in(valid_in3),
        .ready_in(ready_in3), .data_out_portVC(data_out3), .valid_out_portVC(valid_out3),
        .ready_out_portVC(ready_out3), .vc_full(vc_full3), .vc_error(vc_error3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock of main-DUT stimulus. Called at posedge+1; checks the
    // combinational and head outputs against the reference queues before the
    // edge, then retires the predicted pops and pushes after it.
    task automatic cycle(input logic vld, input logic [1:0] vc, input logic [31:0] d,
                         input logic [3:0] pop);
        logic       exp_rdy;
        logic [3:0] exp_v;
        logic [3:0] exp_f;
        valid_in  = vld;
        vc_in     = vc;
        data_in   = d;
        ready_out = pop;
        #1;
        exp_rdy = (mdl[vc].size() < 4);
        chk("ready_in", 64'(ready_in), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = (mdl[i].size() != 0);
            exp_f[i] = (mdl[i].size() == 4);
            if (mdl[i].size() == 0) begin
                chk("head_empty_zero", 64'(data_out[i*32 +: 32]), 64'd0);
            end else begin
                chk("head_data", 64'(data_out[i*32 +: 32]), 64'(mdl[i][0]));
            end
        end
        chk("valid_out", 64'(valid_out), 64'(exp_v));
        chk("vc_full", 64'(vc_full), 64'(exp_f));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && mdl[i].size() != 0) begin
                void'(mdl[i].pop_front());
            end
        end
        if (vld && exp_rdy) begin
            mdl[vc].push_back(d);
        end
        valid_in  = 1'b0;
        ready_out = 4'b0000;
    endtask

    initial begin
        // Rows: vld, vc, data, pop, expected ready_in, valid_out, vc_full (before the edge).
        tbl[0]  = '{1'b1, 2'd2, 32'h0000_00A0, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 2'd2, 32'h0000_0000, 4'b0100, 1'b1, 4'b0100, 4'b0000};
        tbl[2]  = '{1'b0, 2'd0, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b1, 2'd1, 32'h0000_0001, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b1, 2'd1, 32'h0000_0002, 4'b0000, 1'b1, 4'b0010, 4'b0000};
        tbl[5]  = '{1'b1, 2'd1, 32'h0000_0003, 4'b0000, 1'b1, 4'b0010, 4'b0000};
        tbl[6]  = '{1'b1, 2'd1, 32'h0000_0004, 4'b0000, 1'b1, 4'b0010, 4'b0000};
        tbl[7]  = '{1'b0, 2'd1, 32'h0000_0000, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        tbl[8]  = '{1'b0, 2'd0, 32'h0000_0000, 4'b0000, 1'b1, 4'b0010, 4'b0010};
        tbl[9]  = '{1'b0, 2'd0, 32'h0000_0000, 4'b0010, 1'b1, 4'b0010, 4'b0010};
        tbl[10] = '{1'b0, 2'd0, 32'h0000_0000, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        tbl[11] = '{1'b0, 2'd0, 32'h0000_0000, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        tbl[12] = '{1'b0, 2'd0, 32'h0000_0000, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        tbl[13] = '{1'b0, 2'd0, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 4'b0000};

        rst        = 1'b1;
        rst3       = 1'b1;
        data_in    = 32'd0;
        vc_in      = 2'd0;
        valid_in   = 1'b0;
        ready_out  = 4'b0000;
        data_in3   = 32'd0;
        vc_in3     = 2'd0;
        valid_in3  = 1'b0;
        ready_out3 = 3'b000;

        // Reset state.
        #2;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_vc_full", 64'(vc_full), 64'd0);
        chk("rst_vc_error", 64'(vc_error), 64'd0);
        chk("rst_data_out", 64'(data_out[63:0]) | 64'(data_out[127:64]), 64'd0);
        chk("rst_ready_in", 64'(ready_in), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst3 = 1'b0;

        // Single flit on VC2, then VC1 fill to full and in-order drain.
        for (int r = 0; r < 14; r++) begin
            valid_in  = tbl[r].vld;
            vc_in     = tbl[r].vc;
            data_in   = tbl[r].data;
            ready_out = tbl[r].pop;
            #1;
            chk($sformatf("tbl%0d_ready_in", r), 64'(ready_in), 64'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_valid_out", r), 64'(valid_out), 64'(tbl[r].exp_valid));
            chk($sformatf("tbl%0d_vc_full", r), 64'(vc_full), 64'(tbl[r].exp_full));
            cycle(tbl[r].vld, tbl[r].vc, tbl[r].data, tbl[r].pop);
        end

        // Push on a full VC with a same-cycle pop is refused; the slot is usable next cycle.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'd1, 32'h10 + 32'(k), 4'b0000);
        end
        chk("full_before_pop", 64'(vc_full), 64'b0010);
        valid_in = 1'b1; vc_in = 2'd1; data_in = 32'h55; ready_out = 4'b0010;
        #1;
        chk("push_on_full_refused", 64'(ready_in), 64'd0);
        cycle(1'b1, 2'd1, 32'h55, 4'b0010);
        chk("count3_not_full", 64'(vc_full), 64'd0);
        chk("count3_model", 64'(mdl[1].size()), 64'd3);
        cycle(1'b1, 2'd1, 32'h55, 4'b0000);
        chk("count4_full_again", 64'(vc_full), 64'b0010);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 2'd0, 32'd0, 4'b0010);
        end
        chk("vc1_drained", 64'(valid_out), 64'd0);

        // Steady push+pop on VC0 across several pointer wraps.
        cycle(1'b1, 2'd0, 32'h100, 4'b0000);
        cycle(1'b1, 2'd0, 32'h101, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 2'd0, 32'h102 + 32'(k), 4'b0001);
            chk("steady_valid", 64'(valid_out), 64'b0001);
        end
        chk("steady_count_model", 64'(mdl[0].size()), 64'd2);
        // Independent VCs: push VC3 while popping VC0.
        cycle(1'b1, 2'd3, 32'h300, 4'b0001);
        cycle(1'b0, 2'd0, 32'd0, 4'b0001);
        chk("indep_valid", 64'(valid_out), 64'b1000);
        cycle(1'b0, 2'd0, 32'd0, 4'b1000);

        // Illegal tag on a 3-VC instance: consumed, no FIFO change, sticky error.
        valid_in3 = 1'b1; vc_in3 = 2'd0; data_in3 = 32'h77;
        @(posedge clk); #1;
        valid_in3 = 1'b1; vc_in3 = 2'd3; data_in3 = 32'h99;
        #1;
        chk("bad_tag_ready", 64'(ready_in3), 64'd1);
        chk("bad_tag_err_before", 64'(vc_error3), 64'd0);
        @(posedge clk); #1;
        valid_in3 = 1'b0;
        chk("bad_tag_err_set", 64'(vc_error3), 64'd1);
        chk("bad_tag_valid", 64'(valid_out3), 64'b001);
        chk("bad_tag_full", 64'(vc_full3), 64'd0);
        chk("bad_tag_head0", 64'(data_out3[31:0]), 64'h77);
        chk("bad_tag_other_heads", 64'(data_out3[95:32]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(vc_error3), 64'd1);
        ready_out3 = 3'b001;
        @(posedge clk); #1;
        ready_out3 = 3'b000;
        chk("vc3_pop_empty", 64'(valid_out3), 64'd0);
        chk("err_sticky_after_pop", 64'(vc_error3), 64'd1);
        rst3 = 1'b1;
        #1;
        chk("err_cleared_by_rst", 64'(vc_error3), 64'd0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("main_no_error", 64'(vc_error), 64'd0);

        // Asynchronous reset mid-burst with every VC non-empty and VC0 full.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'd0, 32'h400 + 32'(k), 4'b0000);
        end
        cycle(1'b1, 2'd1, 32'h501, 4'b0000);
        cycle(1'b1, 2'd2, 32'h502, 4'b0000);
        cycle(1'b1, 2'd3, 32'h503, 4'b0000);
        chk("pre_rst_valid", 64'(valid_out), 64'b1111);
        chk("pre_rst_full", 64'(vc_full), 64'b0001);
        valid_in = 1'b1; vc_in = 2'd2; data_in = 32'h600;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(valid_out), 64'd0);
        chk("async_rst_full", 64'(vc_full), 64'd0);
        chk("async_rst_data", 64'(data_out[63:0]) | 64'(data_out[127:64]), 64'd0);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mdl[i].delete();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 2'd3, 32'hBEEF, 4'b0000);
        chk("post_rst_head", 64'(data_out[127:96]), 64'hBEEF);
        cycle(1'b0, 2'd0, 32'd0, 4'b1000);
        cycle(1'b0, 2'd0, 32'd0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
